// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB slave terminating transfers into a DEPTH x 32-bit
// register file at BASE_ADDR, with WAIT_CYCLES wait states per access phase.
// Optional feature macro: APB_SLV_ERR_EN (reports out-of-window accesses on
// pslverr_o; without it pslverr_o is tied low).
module apb_slave_regfile #(
   parameter int unsigned DEPTH       = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic [31:0] paddr_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
   output logic        pready_o,
   output logic [31:0] prdata_o,
   output logic        pslverr_o
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = 8;
   localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT_CYCLES);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        regs_q [DEPTH];
   logic [31:0]        regs_d [DEPTH];

   logic [IDX_W-1:0]   idx;
   logic               hit;
   logic               wr_en;
   logic               unused_addr;

   // Address decode: word index inside the window and window match.
   assign idx         = paddr_i[IDX_W+1:2];
   assign hit         = (paddr_i[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
   assign unused_addr = &{1'b0, paddr_i[1:0]};

   // Completion is purely a function of registered state and wait counter.
   assign pready_o = (state_q == ACCESS) && (cnt_q == WAIT_C);

   // Read data only while a hitting read completes; zero otherwise.
   assign prdata_o = (pready_o && !pwrite_i && hit) ? regs_q[idx] : 32'h0;

`ifdef APB_SLV_ERR_EN
   // Out-of-window accesses complete with an error.
   assign pslverr_o = pready_o & ~hit;
`else
   assign pslverr_o = 1'b0;
`endif

   // Next-state logic: setup detection, wait counting, completion and abort.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (psel_i && !penable_i) begin
               state_d = ACCESS;
               cnt_d   = '0;
            end
         end
         ACCESS: begin
            if (!psel_i) begin
               state_d = IDLE;
            end else if (pready_o) begin
               if (penable_i) begin
                  state_d = IDLE;
                  wr_en   = pwrite_i & hit;
               end
            end else if (cnt_q != WAIT_C) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Register file next value: commit a hitting write at completion.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_en) begin
         regs_d[idx] = pwdata_i;
      end
   end

   // FSM state and wait counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Register file storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Testbench for apb_slave_regfile: two instances (2 and 0 wait states) on a
// shared APB bus with per-instance select; directed table, corner sequences
// and randomized transfers checked against a behavioural register model.
module tb_apb_slave_regfile;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef APB_SLV_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [1:0]  psel;
   logic        penable;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic        pready0, pready1;
   logic [31:0] prdata0, prdata1;
   logic        pslverr0, pslverr1;
   logic        cur;

   logic        pready_m;
   logic [31:0] prdata_m;
   logic        pslverr_m;

   int checks;
   int errors;

   logic [31:0] model [2][DEPTH];

   apb_slave_regfile #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_dut0 (
      .clk(clk), .rst(rst), .psel_i(psel[0]), .penable_i(penable),
      .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
      .pready_o(pready0), .prdata_o(prdata0), .pslverr_o(pslverr0)
   );

   apb_slave_regfile #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut1 (
      .clk(clk), .rst(rst), .psel_i(psel[1]), .penable_i(penable),
      .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
      .pready_o(pready1), .prdata_o(prdata1), .pslverr_o(pslverr1)
   );

   assign pready_m  = cur ? pready1  : pready0;
   assign prdata_m  = cur ? prdata1  : prdata0;
   assign pslverr_m = cur ? pslverr1 : pslverr0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int waits(input int s);
      return (s == 0) ? 2 : 0;
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      return (a / (DEPTH * 4)) == (BASE / (DEPTH * 4));
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < int'(DEPTH); i++)
            model[s][i] = 32'h0;
   endtask

   task automatic idle();
      @(negedge clk);
      psel    = 2'b00;
      penable = 1'b0;
   endtask

   // One APB transfer; returns completion data and cycles from setup to ready.
   task automatic xfer(input int s, input logic [31:0] a, input logic w,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic er, output int cyc, output bit ok);
      @(negedge clk);
      cur     = (s != 0);
      psel    = 2'b00;
      psel[s] = 1'b1;
      penable = 1'b0;
      paddr   = a;
      pwrite  = w;
      pwdata  = d;
      cyc     = 1;
      ok      = 1'b0;
      rd      = 32'h0;
      er      = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      for (int k = 0; k < 300; k++) begin
         #1;
         cyc++;
         if (pready_m) begin
            rd = prdata_m;
            er = pslverr_m;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Transfer checked against the model; model updated on hitting writes.
   task automatic xfer_chk(input int s, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input string nm);
      logic [31:0] rd;
      logic [31:0] exp_rd;
      logic        er;
      int          cyc;
      bit          ok;
      bit          h;
      h      = m_hit(a);
      exp_rd = (!w && h) ? model[s][m_idx(a)] : 32'h0;
      xfer(s, a, w, d, rd, er, cyc, ok);
      chk({nm, "_done"}, 32'(ok), 32'd1);
      chk({nm, "_rdata"}, rd, exp_rd);
      chk({nm, "_err"}, 32'(er), 32'(ERR_EN && !h));
      chk({nm, "_cycles"}, 32'(cyc), 32'(2 + waits(s)));
      if (w && h) model[s][m_idx(a)] = d;
   endtask

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl [9];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          cyc;
      bit          ok;
      logic [31:0] a;
      int          s;

      checks  = 0;
      errors  = 0;
      cur     = 1'b0;
      psel    = 2'b00;
      penable = 1'b0;
      paddr   = 32'h0;
      pwrite  = 1'b0;
      pwdata  = 32'h0;
      clear_model();

      tbl[0] = '{1'b1, 32'h0000_0008, 32'hA5A5_0001, 32'h0,         1'b0};
      tbl[1] = '{1'b0, 32'h0000_0008, 32'h0,         32'hA5A5_0001, 1'b0};
      tbl[2] = '{1'b0, 32'h0000_002C, 32'h0,         32'h0,         1'b0};
      tbl[3] = '{1'b1, 32'h0000_002C, 32'hCAFE_F00D, 32'h0,         1'b0};
      tbl[4] = '{1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0,         ERR_EN};
      tbl[5] = '{1'b0, 32'h0000_002C, 32'h0,         32'hCAFE_F00D, 1'b0};
      tbl[6] = '{1'b0, 32'hDEAD_BEEF, 32'h0,         32'h0,         ERR_EN};
      tbl[7] = '{1'b0, 32'h0000_002F, 32'h0,         32'hCAFE_F00D, 1'b0};
      tbl[8] = '{1'b0, 32'h0000_0040, 32'h0,         32'h0,         ERR_EN};

      // Reset and idle outputs
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_pready", 32'(pready0), 32'd0);
      chk("rst_prdata", prdata0, 32'h0);
      chk("rst_pslverr", 32'(pslverr0), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table on the 2-wait instance
      for (int i = 0; i < 9; i++) begin
         xfer(0, tbl[i].a, tbl[i].w, tbl[i].d, rd, er, cyc, ok);
         chk($sformatf("tbl%0d_done", i), 32'(ok), 32'd1);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
         chk($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'd4);
         if (tbl[i].w && m_hit(tbl[i].a)) model[0][m_idx(tbl[i].a)] = tbl[i].d;
         if (i % 3 == 2) idle();
      end
      idle();

      // Zero-wait instance: 2-cycle transfers
      xfer_chk(1, 32'h0000_003C, 1'b1, 32'h1234_5678, "zw_wr");
      xfer_chk(1, 32'h0000_003C, 1'b0, 32'h0, "zw_rd");
      idle();

      // Abort: psel dropped after one access cycle
      xfer_chk(0, 32'h0000_0004, 1'b1, 32'h0000_0404, "ab_pre");
      idle();
      @(negedge clk);
      cur = 1'b0; psel = 2'b01; penable = 1'b0;
      paddr = 32'h0000_0004; pwrite = 1'b1; pwdata = 32'hBAD0_BAD0;
      @(negedge clk);
      penable = 1'b1;
      #1 chk("ab_acc1_pready", 32'(pready0), 32'd0);
      @(negedge clk);
      psel = 2'b00; penable = 1'b0;
      #1 chk("ab_drop_pready", 32'(pready0), 32'd0);
      @(negedge clk);
      #1 chk("ab_idle_pready", 32'(pready0), 32'd0);
      xfer_chk(0, 32'h0000_0004, 1'b0, 32'h0, "ab_rd");
      xfer_chk(0, 32'h0000_0018, 1'b1, 32'h0000_1818, "ab_next");
      idle();

      // Reset during the second wait cycle of a write
      @(negedge clk);
      cur = 1'b0; psel = 2'b01; penable = 1'b0;
      paddr = 32'h0000_0010; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rstmid_pready", 32'(pready0), 32'd0);
      @(negedge clk);
      psel = 2'b00; penable = 1'b0;
      rst = 1'b0;
      clear_model();
      xfer_chk(0, 32'h0000_0010, 1'b0, 32'h0, "rstmid_rd10");
      xfer_chk(0, 32'h0000_0008, 1'b0, 32'h0, "rstmid_rd08");
      idle();

      // Reset while the zero-wait instance is showing ready
      xfer_chk(1, 32'h0000_0020, 1'b1, 32'h0000_2020, "rstrdy_pre");
      idle();
      @(negedge clk);
      cur = 1'b1; psel = 2'b10; penable = 1'b0;
      paddr = 32'h0000_0020; pwrite = 1'b1; pwdata = 32'h5555_AAAA;
      @(negedge clk);
      penable = 1'b1;
      #1 chk("rstrdy_before", 32'(pready1), 32'd1);
      rst = 1'b1;
      #1 chk("rstrdy_after", 32'(pready1), 32'd0);
      @(negedge clk);
      psel = 2'b00; penable = 1'b0;
      rst = 1'b0;
      clear_model();
      xfer_chk(1, 32'h0000_0020, 1'b0, 32'h0, "rstrdy_rd");
      idle();

      // Back-to-back writes then reads across the whole file
      for (int i = 0; i < int'(DEPTH); i++)
         xfer_chk(0, 32'(i * 4), 1'b1, 32'(i * 3), $sformatf("b2b_wr%0d", i));
      for (int i = 0; i < int'(DEPTH); i++)
         xfer_chk(0, 32'(i * 4), 1'b0, 32'h0, $sformatf("b2b_rd%0d", i));
      idle();

      // Randomized transfers against the model
      for (int n = 0; n < 200; n++) begin
         s = int'($urandom_range(1, 0));
         if ($urandom_range(3, 0) == 0) a = $urandom;
         else a = BASE + 32'($urandom_range(DEPTH * 4 - 1, 0));
         xfer_chk(s, a, 1'($urandom_range(1, 0)), $urandom, $sformatf("rnd%0d", n));
         if ($urandom_range(2, 0) == 0) idle();
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
